// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: bundle between the decode stage and the ID/EX register.
//   master : decode side, drives decode/forwarding inputs, observes EX outputs
//   slave  : id_ex_stage, consumes decode inputs, drives registered EX outputs
// Signals:
//   stall, flush, in_valid            control for the register slot
//   rd1, rd2, rs, rt                  register operands and their addresses
//   imm, immse, alusrc, aluop         immediate, extension mode, B select, ALU op
//   regwrite, waddr                   destination write enable / address
//   em_regwrite, em_waddr, em_result  EX/MEM forwarding source
//   mw_regwrite, mw_waddr, mw_result  MEM/WB forwarding source
//   a, b, op, out_valid, regwrite_e, waddr_e, stall_cnt  registered EX outputs
interface id_ex_stage_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned OPW   = 3,
  parameter int unsigned REGW  = 5,
  parameter int unsigned CNTW  = 16
);
  logic             stall;
  logic             flush;
  logic             in_valid;
  logic [WIDTH-1:0] rd1;
  logic [WIDTH-1:0] rd2;
  logic [REGW-1:0]  rs;
  logic [REGW-1:0]  rt;
  logic [15:0]      imm;
  logic             immse;
  logic             alusrc;
  logic [OPW-1:0]   aluop;
  logic             regwrite;
  logic [REGW-1:0]  waddr;
  logic             em_regwrite;
  logic [REGW-1:0]  em_waddr;
  logic [WIDTH-1:0] em_result;
  logic             mw_regwrite;
  logic [REGW-1:0]  mw_waddr;
  logic [WIDTH-1:0] mw_result;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [OPW-1:0]   op;
  logic             out_valid;
  logic             regwrite_e;
  logic [REGW-1:0]  waddr_e;
  logic [CNTW-1:0]  stall_cnt;

  modport master (
    output stall, flush, in_valid, rd1, rd2, rs, rt, imm, immse, alusrc, aluop,
           regwrite, waddr, em_regwrite, em_waddr, em_result,
           mw_regwrite, mw_waddr, mw_result,
    input  a, b, op, out_valid, regwrite_e, waddr_e, stall_cnt
  );

  modport slave (
    input  stall, flush, in_valid, rd1, rd2, rs, rt, imm, immse, alusrc, aluop,
           regwrite, waddr, em_regwrite, em_waddr, em_result,
           mw_regwrite, mw_waddr, mw_result,
    output a, b, op, out_valid, regwrite_e, waddr_e, stall_cnt
  );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID->EX pipeline register in front of the execute ALU.
// Operand B selection (register vs extended immediate) and optional EX/MEM,
// MEM/WB forwarding are resolved combinationally before the register, so the
// ALU only sees registered a/b/op. Supports stall (hold), flush (bubble),
// a valid bit and a saturating count of stalled valid cycles.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous reset, active-high
//   bus  id_ex_stage_if.slave (decode inputs in, registered EX outputs out)
// Configuration:
//   ID_EX_FWD_EN  defined   -> forwarding muxes on operands A and B (rt path)
//                 undefined -> operands come straight from rd1/rd2; em_*/mw_*
//                              are ignored and hazards need external stalls
module id_ex_stage #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned OPW   = 3,
  parameter int unsigned REGW  = 5,
  parameter int unsigned CNTW  = 16
) (
  input logic         clk,
  input logic         rst,
  id_ex_stage_if.slave bus
);

  logic [WIDTH-1:0] ext_imm;
  logic [WIDTH-1:0] opa_next;
  logic [WIDTH-1:0] rt_val;
  logic [WIDTH-1:0] opb_next;

`ifdef ID_EX_FWD_EN
  // EX/MEM is checked first so the younger result wins; r0 is never forwarded.
  function automatic logic [WIDTH-1:0] fwd(
    input logic [REGW-1:0]  r,
    input logic [WIDTH-1:0] d,
    input logic             emw,
    input logic [REGW-1:0]  ema,
    input logic [WIDTH-1:0] emr,
    input logic             mww,
    input logic [REGW-1:0]  mwa,
    input logic [WIDTH-1:0] mwr
  );
    logic [WIDTH-1:0] v;
    v = d;
    if (r != '0) begin
      if (emw && (ema == r))      v = emr;
      else if (mww && (mwa == r)) v = mwr;
    end
    return v;
  endfunction

  always_comb begin
    opa_next = fwd(bus.rs, bus.rd1, bus.em_regwrite, bus.em_waddr, bus.em_result,
                   bus.mw_regwrite, bus.mw_waddr, bus.mw_result);
    rt_val   = fwd(bus.rt, bus.rd2, bus.em_regwrite, bus.em_waddr, bus.em_result,
                   bus.mw_regwrite, bus.mw_waddr, bus.mw_result);
  end
`else
  logic unused_fwd;

  always_comb begin
    opa_next = bus.rd1;
    rt_val   = bus.rd2;
  end

  assign unused_fwd = ^{bus.rs, bus.rt, bus.em_regwrite, bus.em_waddr, bus.em_result,
                        bus.mw_regwrite, bus.mw_waddr, bus.mw_result};
`endif

  // Upper bits replicate imm[15] only when sign extension is selected.
  always_comb begin
    ext_imm  = {{(WIDTH-16){bus.imm[15] & bus.immse}}, bus.imm};
    opb_next = bus.alusrc ? ext_imm : rt_val;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.a          <= '0;
      bus.b          <= '0;
      bus.op         <= '0;
      bus.out_valid  <= 1'b0;
      bus.regwrite_e <= 1'b0;
      bus.waddr_e    <= '0;
      bus.stall_cnt  <= '0;
    end else if (bus.flush) begin
      bus.a          <= '0;
      bus.b          <= '0;
      bus.op         <= '0;
      bus.out_valid  <= 1'b0;
      bus.regwrite_e <= 1'b0;
      bus.waddr_e    <= '0;
    end else if (bus.stall) begin
      if (bus.out_valid && (bus.stall_cnt != '1)) begin
        bus.stall_cnt <= bus.stall_cnt + CNTW'(1);
      end
    end else begin
      bus.a          <= opa_next;
      bus.b          <= opb_next;
      bus.op         <= bus.aluop;
      bus.out_valid  <= bus.in_valid;
      bus.regwrite_e <= bus.regwrite & bus.in_valid;
      bus.waddr_e    <= bus.waddr;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed bench for id_ex_stage. A behavioural model tracks
// the expected outputs from the decode inputs; a negedge process compares the
// DUT against it every cycle, and literal checks pin the model at key points.
module tb_id_ex_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  id_ex_stage_if #(.WIDTH(32), .OPW(3), .REGW(5), .CNTW(16)) bus ();

  id_ex_stage #(.WIDTH(32), .OPW(3), .REGW(5), .CNTW(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic        m_ok = 1'b0;
  logic [31:0] m_a, m_b;
  logic [2:0]  m_op;
  logic        m_valid, m_rw;
  logic [4:0]  m_wa;
  int unsigned m_cnt;

  function automatic logic [31:0] mfwd(input logic [4:0] r, input logic [31:0] d);
`ifdef ID_EX_FWD_EN
    if (r != 0 && bus.em_regwrite && bus.em_waddr == r) return bus.em_result;
    if (r != 0 && bus.mw_regwrite && bus.mw_waddr == r) return bus.mw_result;
`endif
    return d;
  endfunction

  function automatic logic [31:0] mext(input logic [15:0] i, input logic se);
    int signed s;
    if (!se) return {16'h0000, i};
    s = $signed(i);
    return 32'(s);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_ok <= 1'b1;
      {m_a, m_b, m_op, m_valid, m_rw, m_wa} <= '0;
      m_cnt <= 0;
    end else if (bus.flush) begin
      {m_a, m_b, m_op, m_valid, m_rw, m_wa} <= '0;
    end else if (bus.stall) begin
      if (m_valid) m_cnt <= (m_cnt >= 65535) ? 65535 : m_cnt + 1;
    end else begin
      m_a     <= mfwd(bus.rs, bus.rd1);
      m_b     <= bus.alusrc ? mext(bus.imm, bus.immse) : mfwd(bus.rt, bus.rd2);
      m_op    <= bus.aluop;
      m_valid <= bus.in_valid;
      m_rw    <= bus.regwrite && bus.in_valid;
      m_wa    <= bus.waddr;
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("a", 64'(bus.a), 64'(m_a));
      chk("b", 64'(bus.b), 64'(m_b));
      chk("op", 64'(bus.op), 64'(m_op));
      chk("out_valid", 64'(bus.out_valid), 64'(m_valid));
      chk("regwrite_e", 64'(bus.regwrite_e), 64'(m_rw));
      chk("waddr_e", 64'(bus.waddr_e), 64'(m_wa));
      chk("stall_cnt", 64'(bus.stall_cnt), 64'(m_cnt));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic load(input logic [31:0] r1, input logic [31:0] r2, input logic [4:0] s,
                      input logic [4:0] t, input logic [2:0] aop, input logic v,
                      input logic rw, input logic [4:0] wa);
    bus.rd1 = r1; bus.rd2 = r2; bus.rs = s; bus.rt = t;
    bus.aluop = aop; bus.in_valid = v; bus.regwrite = rw; bus.waddr = wa;
  endtask

  initial begin
    bus.stall = 0; bus.flush = 0; bus.in_valid = 0;
    bus.rd1 = 0; bus.rd2 = 0; bus.rs = 0; bus.rt = 0;
    bus.imm = 0; bus.immse = 0; bus.alusrc = 0; bus.aluop = 0;
    bus.regwrite = 0; bus.waddr = 0;
    bus.em_regwrite = 0; bus.em_waddr = 0; bus.em_result = 0;
    bus.mw_regwrite = 0; bus.mw_waddr = 0; bus.mw_result = 0;

    // reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_a", 64'(bus.a), 64'h0);
    chk("rst_op", 64'(bus.op), 64'h0);
    chk("rst_valid", 64'(bus.out_valid), 64'h0);
    chk("rst_cnt", 64'(bus.stall_cnt), 64'h0);

    // basic load
    load(32'h0000_F0F0, 32'h0000_0FF0, 5'd1, 5'd2, 3'b001, 1'b1, 1'b1, 5'd7);
    tick();
    chk("ld_a", 64'(bus.a), 64'h0000_F0F0);
    chk("ld_b", 64'(bus.b), 64'h0000_0FF0);
    chk("ld_op", 64'(bus.op), 64'h1);
    chk("ld_valid", 64'(bus.out_valid), 64'h1);
    chk("ld_rw", 64'(bus.regwrite_e), 64'h1);

    // immediate extension
    bus.alusrc = 1; bus.imm = 16'h8001; bus.immse = 1;
    tick();
    chk("imm_se", 64'(bus.b), 64'hFFFF_8001);
    bus.immse = 0;
    tick();
    chk("imm_ze", 64'(bus.b), 64'h0000_8001);
    bus.alusrc = 0;

    // forwarding
    load(32'h1111_1111, 32'h2222_2222, 5'd5, 5'd5, 3'b011, 1'b1, 1'b0, 5'd9);
    bus.em_regwrite = 1; bus.em_waddr = 5; bus.em_result = 32'hAAAA_0000;
    bus.mw_regwrite = 1; bus.mw_waddr = 5; bus.mw_result = 32'h1234_5678;
    tick();
`ifdef ID_EX_FWD_EN
    chk("fwd_em", 64'(bus.a), 64'hAAAA_0000);
    chk("fwd_em_b", 64'(bus.b), 64'hAAAA_0000);
`else
    chk("nofwd_a", 64'(bus.a), 64'h1111_1111);
    chk("nofwd_b", 64'(bus.b), 64'h2222_2222);
`endif
    bus.em_regwrite = 0;
    tick();
`ifdef ID_EX_FWD_EN
    chk("fwd_mw", 64'(bus.a), 64'h1234_5678);
`else
    chk("nofwd_a2", 64'(bus.a), 64'h1111_1111);
`endif
    bus.rs = 0; bus.em_regwrite = 1; bus.em_waddr = 0; bus.mw_waddr = 0;
    tick();
    chk("fwd_r0", 64'(bus.a), 64'h1111_1111);
    bus.rs = 3; bus.rt = 4; bus.em_waddr = 4; bus.mw_waddr = 3;
    tick();
    bus.em_regwrite = 0; bus.mw_regwrite = 0;

    // invalid slot still captures operands
    load(32'hDEAD_BEEF, 32'h0BAD_F00D, 5'd6, 5'd8, 3'b100, 1'b0, 1'b1, 5'd12);
    tick();
    chk("inv_valid", 64'(bus.out_valid), 64'h0);
    chk("inv_rw", 64'(bus.regwrite_e), 64'h0);
    chk("inv_a", 64'(bus.a), 64'hDEAD_BEEF);

    // stall hold and counting, then flush overriding stall
    load(32'h0000_00A5, 32'h0000_005A, 5'd1, 5'd2, 3'b010, 1'b1, 1'b1, 5'd3);
    tick();
    bus.stall = 1;
    for (int i = 0; i < 3; i++) begin
      load(32'(i * 17 + 1), 32'(i * 31 + 2), 5'd1, 5'd2, 3'(i + 3), 1'b1, 1'b0, 5'(i));
      tick();
    end
    chk("stl_a", 64'(bus.a), 64'h0000_00A5);
    chk("stl_op", 64'(bus.op), 64'h2);
    chk("stl_cnt", 64'(bus.stall_cnt), 64'd3);
    bus.flush = 1;
    tick();
    chk("fl_valid", 64'(bus.out_valid), 64'h0);
    chk("fl_rw", 64'(bus.regwrite_e), 64'h0);
    chk("fl_cnt", 64'(bus.stall_cnt), 64'd3);
    bus.flush = 0;
    tick();
    tick();
    chk("stl_novalid_cnt", 64'(bus.stall_cnt), 64'd3);

    // reset mid-stall
    bus.stall = 0;
    load(32'h0000_0001, 32'h0000_0002, 5'd1, 5'd2, 3'b000, 1'b1, 1'b1, 5'd4);
    tick();
    bus.stall = 1;
    tick();
    tick();
    chk("pre_rst_cnt", 64'(bus.stall_cnt), 64'd5);
    rst = 1;
    tick();
    rst = 0;
    chk("mid_rst_valid", 64'(bus.out_valid), 64'h0);
    chk("mid_rst_cnt", 64'(bus.stall_cnt), 64'd0);

    // saturation
    bus.stall = 0;
    tick();
    bus.stall = 1;
    repeat (65540) @(posedge clk);
    #2;
    chk("sat_cnt", 64'(bus.stall_cnt), 64'hFFFF);
    tick();
    chk("sat_hold", 64'(bus.stall_cnt), 64'hFFFF);
    bus.stall = 0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
